// File: rtl/io_poll_pkg.sv
// rtl/io_poll_pkg.sv - shared widths, event encoding and FSM states for the IO poll scheduler
package io_poll_pkg;

  localparam int N_BTN        = 5;
  localparam int N_SW         = 8;
  localparam int N_IN         = N_BTN + N_SW;
  localparam int EVT_KIND_BIT = 7;
  localparam int EVT_LVL_BIT  = 6;
  localparam int EVT_IDX_MSB  = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SAMPLE,
    ST_COMPARE,
    ST_SCAN
  } poll_state_t;

  // Flat input index -> event code; buttons occupy indices 0..N_BTN-1
  function automatic logic [7:0] make_evt(input logic [3:0] idx, input logic level);
    logic [7:0] code;
    code = 8'h00;
    if (idx < 4'(N_BTN)) begin
      code[EVT_IDX_MSB:0] = idx;
    end else begin
      code[EVT_KIND_BIT]  = 1'b1;
      code[EVT_IDX_MSB:0] = idx - 4'(N_BTN);
    end
    code[EVT_LVL_BIT] = level;
    return code;
  endfunction

endpackage

// File: rtl/io_evt_fifo.sv
// rtl/io_evt_fifo.sv - event FIFO with registered storage; a push while full is taken only alongside a pop
module io_evt_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_data
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_pop;
  logic             w_do_push;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  // Storage is not reset, so the head is masked while empty
  assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/io_poll_scheduler.sv
// rtl/io_poll_scheduler.sv - tick-paced debounce of buttons/switches, per-bit change events into a FIFO
module io_poll_scheduler
  import io_poll_pkg::*;
#(
  parameter int POLL_DIV   = 100000,
  parameter int STABLE_N   = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] button,
  input  logic [7:0] SW,
  output logic [4:0] btn_stable,
  output logic [7:0] sw_stable,
  output logic       evt_valid,
  output logic [7:0] evt_code,
  input  logic       evt_ready,
  output logic       overflow,
  input  logic       clr_overflow
);

  localparam int CNT_W = $clog2(POLL_DIV);

  poll_state_t      r_state;
  poll_state_t      w_state_next;
  logic [CNT_W-1:0] r_tick_cnt;
  logic             w_tick;
  logic [N_IN-1:0]  r_raw;
  logic [N_IN-1:0]  r_last_raw;
  logic [N_IN-1:0]  r_accepted;
  logic [N_IN-1:0]  r_change_mask;
  logic [3:0]       r_stable_cnt;
  logic [3:0]       w_cnt_upd;
  logic [3:0]       r_idx;
  logic             w_accept;
  logic             w_push;
  logic             w_fifo_full;
  logic             w_fifo_empty;
  logic             w_drop;

  assign w_tick = (r_tick_cnt == CNT_W'(POLL_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_tick_cnt <= '0;
    else if (w_tick) r_tick_cnt <= '0;
    else             r_tick_cnt <= r_tick_cnt + 1'b1;
  end

  // Saturating run length of identical samples
  always_comb begin
    w_cnt_upd = 4'd1;
    if (r_raw == r_last_raw) begin
      w_cnt_upd = (r_stable_cnt >= 4'(STABLE_N)) ? 4'(STABLE_N) : r_stable_cnt + 4'd1;
    end
  end

  assign w_accept = (w_cnt_upd == 4'(STABLE_N)) && (r_raw != r_accepted);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_push       = 1'b0;
    case (r_state)
      ST_IDLE:    if (w_tick) w_state_next = ST_SAMPLE;
      ST_SAMPLE:  w_state_next = ST_COMPARE;
      ST_COMPARE: w_state_next = w_accept ? ST_SCAN : ST_IDLE;
      ST_SCAN: begin
        w_push = r_change_mask[r_idx];
        if (r_idx == 4'(N_IN - 1)) w_state_next = ST_IDLE;
      end
      default:    w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_raw         <= '0;
      r_last_raw    <= '0;
      r_accepted    <= '0;
      r_change_mask <= '0;
      r_stable_cnt  <= '0;
      r_idx         <= '0;
    end else begin
      case (r_state)
        ST_SAMPLE: r_raw <= {SW, button};
        ST_COMPARE: begin
          r_stable_cnt <= w_cnt_upd;
          if (r_raw != r_last_raw) r_last_raw <= r_raw;
          if (w_accept) begin
            r_change_mask <= r_raw ^ r_accepted;
            r_accepted    <= r_raw;
            r_idx         <= '0;
          end
        end
        ST_SCAN:   r_idx <= r_idx + 4'd1;
        default:   ;
      endcase
    end
  end

  io_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_evt_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (make_evt(r_idx, r_accepted[r_idx])),
    .i_pop   (evt_ready),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_data  (evt_code)
  );

  assign w_drop = w_push && w_fifo_full && !(evt_ready && !w_fifo_empty);

  // A drop in the same cycle as a clear leaves the flag set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            overflow <= 1'b0;
    else if (w_drop)       overflow <= 1'b1;
    else if (clr_overflow) overflow <= 1'b0;
  end

  assign evt_valid  = !w_fifo_empty;
  assign btn_stable = r_accepted[N_BTN-1:0];
  assign sw_stable  = r_accepted[N_IN-1:N_BTN];

endmodule
